// File: rtl/fft_pkg.sv
// Shared FFT definitions: control-state encoding, default sizing, bit-reversal helper.
package fft_pkg;

    localparam int unsigned DEFAULT_LOG_N      = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH = 36;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    // Reverse the low log_n bits of value (log_n <= 16); upper bits of the result are zero.
    function automatic logic [15:0] bitrev(input logic [15:0] value, input int unsigned log_n);
        logic [15:0] result;
        result = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < log_n) begin
                result[4'(i)] = value[4'(log_n - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage array is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no read is issued; cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bitrev_reorder.sv
// Double-buffered bit-reversal reorder: writes natural order into one bank while
// reading the previously completed bank in bit-reversed order.
module bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LOG_N      = DEFAULT_LOG_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync_in,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    output logic                  sync_out
);

    localparam logic [LOG_N-1:0] LAST_IDX = '1;

    state_t           state_q, state_d;
    logic [LOG_N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             dvalid_d, sync_d;

    logic             wr_en, rd_en;
    logic [LOG_N:0]   wr_addr, rd_addr;
    logic [LOG_N-1:0] rev_idx;
    logic             resync;

    assign rev_idx = LOG_N'(bitrev(16'(wcnt_q), LOG_N));
    assign resync  = sync_in && (wcnt_q != '0);

    // Control state, write counter, bank select and output flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            wbank_q  <= 1'b0;
            dvalid   <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wbank_q  <= wbank_d;
            dvalid   <= dvalid_d;
            sync_out <= sync_d;
        end
    end

    // Next-state, RAM port control and output-flag decode.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        wr_en    = 1'b0;
        wr_addr  = {wbank_q, wcnt_q};
        rd_en    = 1'b0;
        rd_addr  = {~wbank_q, rev_idx};
        dvalid_d = 1'b0;
        sync_d   = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (sync_in) begin
                        wr_en   = 1'b1;
                        wr_addr = {wbank_q, {LOG_N{1'b0}}};
                        wcnt_d  = LOG_N'(1);
                        state_d = FILL;
                    end
                end
                FILL, STREAM: begin
                    wr_en = 1'b1;
                    if (resync) begin
                        // Partial frame is dropped; the sync sample restarts the current bank.
                        wr_addr = {wbank_q, {LOG_N{1'b0}}};
                        wcnt_d  = LOG_N'(1);
                        state_d = FILL;
                    end else begin
                        wcnt_d = wcnt_q + LOG_N'(1);
                        if (wcnt_q == LAST_IDX) begin
                            wbank_d = ~wbank_q;
                            state_d = STREAM;
                        end
                        if (state_q == STREAM) begin
                            rd_en    = 1'b1;
                            dvalid_d = 1'b1;
                            sync_d   = (wcnt_q == '0);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(LOG_N + 1)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(din),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(dout)
    );

endmodule

// File: tb/tb_bitrev_reorder.sv
// Self-checking bench for bitrev_reorder with N = 8.
module tb_bitrev_reorder;

    localparam int unsigned DW = 36;
    localparam int unsigned LN = 3;
    localparam int unsigned N  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sync_in;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          sync_out;

    bitrev_reorder #(.DATA_WIDTH(DW), .LOG_N(LN)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_in (sync_in),
        .din     (din),
        .dout    (dout),
        .dvalid  (dvalid),
        .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: frames collected as queues, emitted in reversed-index order.
    bit            m_started;
    bit            m_have_prev;
    logic [DW-1:0] m_cur[$];
    logic [DW-1:0] m_prev[N];
    logic [DW-1:0] e_dout;
    bit            e_valid;
    bit            e_sync;

    logic [DW-1:0] got[$];
    bit            got_sync[$];
    int            exp_q[$];

    typedef struct {
        bit  en;
        bit  sync;
        int  din;
        bit  exp_valid;
        bit  exp_sync;
        int  exp_dout;
    } vec_t;

    vec_t tbl[25];
    int   ord[N];

    function automatic int rev(int x);
        int r = 0;
        for (int b = 0; b < int'(LN); b++) begin
            r = r * 2 + ((x >> b) & 1);
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_started   = 0;
        m_have_prev = 0;
        m_cur.delete();
        e_dout  = '0;
        e_valid = 0;
        e_sync  = 0;
    endfunction

    function automatic void model_step(bit e, bit s, logic [DW-1:0] d);
        int pos;
        e_valid = 0;
        e_sync  = 0;
        if (!e) return;
        if (!m_started) begin
            if (s) begin
                m_cur.delete();
                m_cur.push_back(d);
                m_started = 1;
            end
            return;
        end
        pos = m_cur.size();
        if (s && pos != 0) begin
            m_cur.delete();
            m_cur.push_back(d);
            m_have_prev = 0;
            return;
        end
        if (m_have_prev) begin
            e_valid = 1;
            e_dout  = m_prev[rev(pos)];
            e_sync  = (pos == 0);
        end
        m_cur.push_back(d);
        if (m_cur.size() == int'(N)) begin
            for (int i = 0; i < int'(N); i++) m_prev[i] = m_cur[i];
            m_cur.delete();
            m_have_prev = 1;
        end
    endfunction

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_seq(string name);
        check({name, " count"}, DW'(got.size() >= exp_q.size()), DW'(1));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check(name, got[i], DW'(exp_q[i]));
        end
    endfunction

    task automatic step(bit e, bit s, logic [DW-1:0] d, bit use_model);
        en      = e;
        sync_in = s;
        din     = d;
        @(posedge clk);
        #1;
        if (dvalid) begin
            got.push_back(dout);
            got_sync.push_back(sync_out);
        end
        if (use_model) begin
            model_step(e, s, d);
            check("dvalid", DW'(dvalid), DW'(e_valid));
            check("sync_out", DW'(sync_out), DW'(e_sync));
            check("dout", dout, e_dout);
        end
    endtask

    // Reset asserted between edges with en=1; outputs must clear without a clock edge.
    task automatic do_reset();
        en      = 1'b1;
        sync_in = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("async rst dout", dout, '0);
        check("async rst dvalid", DW'(dvalid), '0);
        check("async rst sync_out", DW'(sync_out), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        got.delete();
        got_sync.delete();
    endtask

    initial begin
        int k;
        rst     = 1'b0;
        en      = 1'b0;
        sync_in = 1'b0;
        din     = '0;
        model_reset();
        #1;
        check("reset dout", dout, '0);
        check("reset dvalid", DW'(dvalid), '0);
        check("reset sync_out", DW'(sync_out), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Data without any sync is ignored.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(i + 1), 1'b1);
        check("no sync no output", DW'(got.size()), '0);

        // Continuous stream from a fixed table.
        ord = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < 25; i++) begin
            tbl[i].en        = 1;
            tbl[i].sync      = (i == 0);
            tbl[i].din       = i;
            tbl[i].exp_valid = (i >= 8);
            tbl[i].exp_sync  = (i >= 8) && (i % 8 == 0);
            tbl[i].exp_dout  = (i >= 8) ? ((i / 8 - 1) * 8 + ord[i % 8]) : 0;
        end
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].en, tbl[i].sync, DW'(tbl[i].din), 1'b0);
            check("tbl dvalid", DW'(dvalid), DW'(tbl[i].exp_valid));
            check("tbl sync_out", DW'(sync_out), DW'(tbl[i].exp_sync));
            check("tbl dout", dout, DW'(tbl[i].exp_dout));
        end

        // Stalls: en alternating.
        do_reset();
        k = 0;
        for (int j = 0; j < 50; j++) begin
            if (j % 2 == 0) begin
                step(1'b1, k == 0, DW'(k), 1'b1);
                k++;
            end else begin
                step(1'b0, 1'b0, DW'(k), 1'b1);
            end
        end
        exp_q = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
        check_seq("stall order");

        // Mid-frame resync at din=11.
        do_reset();
        for (int i = 0; i <= 30; i++) step(1'b1, (i == 0) || (i == 11), DW'(i), 1'b1);
        exp_q = '{0, 4, 2, 11, 15, 13, 17, 12, 16, 14, 18};
        check_seq("resync order");
        check("resync sync at 11", DW'((got_sync.size() > 3) ? got_sync[3] : 1'b0), DW'(1));

        // Sync on every frame boundary.
        do_reset();
        for (int i = 0; i <= 24; i++) step(1'b1, (i % 8) == 0, DW'(i), 1'b1);
        exp_q = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
        check_seq("boundary sync order");

        // Reset in the middle of streaming, then a fresh frame.
        do_reset();
        for (int i = 0; i <= 12; i++) step(1'b1, i == 0, DW'(i), 1'b1);
        din = DW'(13);
        do_reset();
        step(1'b1, 1'b1, DW'(100), 1'b1);
        for (int j = 1; j <= 10; j++) step(1'b1, 1'b0, DW'(100 + j), 1'b1);
        exp_q = '{100, 104, 102};
        check_seq("post reset order");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit e, s;
            e = (i == 0) || ($urandom_range(0, 3) != 0);
            s = (i == 0) || ($urandom_range(0, 29) == 0);
            step(e, s, {$urandom, 4'($urandom)}, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
